// File: rtl/alu_vec_pkg.sv
// ---------------------------------------------------------------------------
// alu_vec_pkg
// Purpose : shared definitions for the lane-parallel vector ALU.
// Contents: opcode enumeration, per-lane flag bit positions and the number
//           of flag bits each lane reports.
// ---------------------------------------------------------------------------
package alu_vec_pkg;

    typedef enum logic [2:0] {
        OP_MUL  = 3'b000,
        OP_SUB  = 3'b001,
        OP_ADD  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_PASS = 3'b110,
        OP_SET  = 3'b111
    } opcode_t;

    // Position of each flag inside a lane's 4-bit {N,Z,C,V} group.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/alu_lane.sv
// ---------------------------------------------------------------------------
// alu_lane
// Purpose : purely combinational single-lane ALU, bits_index bits wide.
// Ports   :
//   a       in  bits_index  lane operand A
//   b       in  bits_index  lane operand B (already muxed with the scalar)
//   c       in  bits_index  scalar / immediate, used only by SET
//   opcode  in  3           operation select (see alu_vec_pkg::opcode_t)
//   result  out bits_index  lane result
//   flags   out 4           {N,Z,C,V}
// ---------------------------------------------------------------------------
module alu_lane
    import alu_vec_pkg::*;
#(
    parameter int bits_index = 8
) (
    input  logic [bits_index-1:0] a,
    input  logic [bits_index-1:0] b,
    input  logic [bits_index-1:0] c,
    input  logic [2:0]            opcode,
    output logic [bits_index-1:0] result,
    output logic [NUM_FLAGS-1:0]  flags
);

    localparam int MSB = bits_index - 1;

    opcode_t                   op;
    logic [bits_index:0]       sum;
    logic [bits_index:0]       diff;
    logic signed [2*bits_index-1:0] prod;
    logic                      mul_ovf;
    logic                      carry;
    logic                      ovf;

    assign op = opcode_t'(opcode);

    // One extra bit on add/sub captures the carry (or inverted borrow).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign prod = $signed(a) * $signed(b);

    // The signed product fits the lane only if its upper half is a pure
    // sign extension of the lane's MSB.
    assign mul_ovf = (prod != {{bits_index{prod[MSB]}}, prod[MSB:0]});

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            OP_MUL: begin
                result = prod[MSB:0];
                carry  = mul_ovf;
                ovf    = mul_ovf;
            end
            OP_SUB: begin
                result = diff[MSB:0];
                carry  = ~diff[bits_index];
                ovf    = (a[MSB] ^ b[MSB]) & (diff[MSB] ^ a[MSB]);
            end
            OP_ADD: begin
                result = sum[MSB:0];
                carry  = sum[bits_index];
                ovf    = ~(a[MSB] ^ b[MSB]) & (sum[MSB] ^ a[MSB]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_PASS: result = b;
            OP_SET:  result = c;
            default: result = '0;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = result[MSB];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/alu_vec.sv
// ---------------------------------------------------------------------------
// alu_vec
// Purpose : SIMD ALU. WIDTH_V is split into NUM_INSTANCES independent lanes
//           of bits_index bits; each lane gets its own alu_lane and results
//           are registered, giving a fixed one-cycle latency.
//           WIDTH_V must be an integer multiple of bits_index.
// Ports   :
//   clk          in  1                 clock, rising edge
//   rst_n        in  1                 synchronous active-low reset
//   a            in  WIDTH_V           vector operand A
//   b            in  WIDTH_V           vector operand B
//   c            in  bits_index        scalar operand / immediate
//   opcode       in  3                 operation select
//   flag_scalar  in  1                 1 = use c as B for every lane
//   result       out WIDTH_V           registered lane results
//   flags        out NUM_INSTANCES*4   registered {N,Z,C,V} per lane
// ---------------------------------------------------------------------------
module alu_vec
    import alu_vec_pkg::*;
#(
    parameter int WIDTH_V    = 128,
    parameter int bits_index = 8,
    localparam int NUM_INSTANCES = WIDTH_V / bits_index
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [WIDTH_V-1:0]             a,
    input  logic [WIDTH_V-1:0]             b,
    input  logic [bits_index-1:0]          c,
    input  logic [2:0]                     opcode,
    input  logic                           flag_scalar,
    output logic [WIDTH_V-1:0]             result,
    output logic [NUM_INSTANCES*NUM_FLAGS-1:0] flags
);

    logic [WIDTH_V-1:0]                     lane_result;
    logic [NUM_INSTANCES*NUM_FLAGS-1:0]     lane_flags;

    genvar i;
    generate
        for (i = 0; i < NUM_INSTANCES; i++) begin : g_lane
            logic [bits_index-1:0] b_sel;

            // In vector-scalar mode every lane sees the same B operand.
            assign b_sel = flag_scalar ? c : b[bits_index*i +: bits_index];

            alu_lane #(
                .bits_index (bits_index)
            ) u_lane (
                .a      (a[bits_index*i +: bits_index]),
                .b      (b_sel),
                .c      (c),
                .opcode (opcode),
                .result (lane_result[bits_index*i +: bits_index]),
                .flags  (lane_flags[NUM_FLAGS*i +: NUM_FLAGS])
            );
        end
    endgenerate

    // Output register: reset wins over any operation on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= '0;
            flags  <= '0;
        end else begin
            result <= lane_result;
            flags  <= lane_flags;
        end
    end

endmodule

// File: tb/tb_alu_vec.sv
// ---------------------------------------------------------------------------
// tb_alu_vec
// Purpose : directed self-checking bench for alu_vec at default parameters
//           (128-bit vector, 16 lanes of 8 bits).
// ---------------------------------------------------------------------------
module tb_alu_vec;
    import alu_vec_pkg::*;

    localparam int W  = 128;
    localparam int BI = 8;
    localparam int NL = W / BI;

    logic              clk;
    logic              rst_n;
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic [BI-1:0]     c;
    logic [2:0]        opcode;
    logic              flag_scalar;
    logic [W-1:0]      result;
    logic [NL*4-1:0]   flags;

    int tests;
    int failed;

    alu_vec #(
        .WIDTH_V    (W),
        .bits_index (BI)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .c           (c),
        .opcode      (opcode),
        .flag_scalar (flag_scalar),
        .result      (result),
        .flags       (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operation, lets it be captured on the next rising edge,
    // then returns 1 time unit later so outputs are sampled off the edge.
    task automatic apply_stimulus(input logic [2:0] op, input logic [W-1:0] av,
                                  input logic [W-1:0] bv, input logic [BI-1:0] cv,
                                  input logic fs);
        opcode      = op;
        a           = av;
        b           = bv;
        c           = cv;
        flag_scalar = fs;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        apply_stimulus(OP_ADD, {16{8'd10}}, {16{8'd20}}, 8'd0, 1'b0);
        tests++;
        if (result !== '0) begin
            failed++;
            $display("[TB] FAIL reset_result: got %h expected %h", result, {W{1'b0}});
        end
        tests++;
        if (flags !== '0) begin
            failed++;
            $display("[TB] FAIL reset_flags: got %h expected %h", flags, {NL*4{1'b0}});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        apply_stimulus(OP_ADD, {16{8'd10}}, {16{8'd20}}, 8'd0, 1'b0);
        tests++;
        if (result !== {16{8'h1E}}) begin
            failed++;
            $display("[TB] FAIL add_result: got %h expected %h", result, {16{8'h1E}});
        end
        tests++;
        if (flags !== {16{4'b0000}}) begin
            failed++;
            $display("[TB] FAIL add_flags: got %h expected %h", flags, {16{4'b0000}});
        end
    endtask

    task automatic test_sub;
        apply_stimulus(OP_SUB, {16{8'd50}}, {16{8'd20}}, 8'd0, 1'b0);
        tests++;
        if (result !== {16{8'h1E}}) begin
            failed++;
            $display("[TB] FAIL sub_pos_result: got %h expected %h", result, {16{8'h1E}});
        end
        tests++;
        if (flags !== {16{4'b0010}}) begin
            failed++;
            $display("[TB] FAIL sub_pos_flags: got %h expected %h", flags, {16{4'b0010}});
        end
        apply_stimulus(OP_SUB, {16{8'd20}}, {16{8'd50}}, 8'd0, 1'b0);
        tests++;
        if (result !== {16{8'hE2}}) begin
            failed++;
            $display("[TB] FAIL sub_neg_result: got %h expected %h", result, {16{8'hE2}});
        end
        tests++;
        if (flags !== {16{4'b1000}}) begin
            failed++;
            $display("[TB] FAIL sub_neg_flags: got %h expected %h", flags, {16{4'b1000}});
        end
        // Equal operands: zero with no borrow.
        apply_stimulus(OP_SUB, {16{8'd7}}, {16{8'd7}}, 8'd0, 1'b0);
        tests++;
        if (flags !== {16{4'b0110}}) begin
            failed++;
            $display("[TB] FAIL sub_eq_flags: got %h expected %h", flags, {16{4'b0110}});
        end
        // -128 - 1 overflows to +127.
        apply_stimulus(OP_SUB, {16{8'h80}}, {16{8'h01}}, 8'd0, 1'b0);
        tests++;
        if (result !== {16{8'h7F}}) begin
            failed++;
            $display("[TB] FAIL sub_ovf_result: got %h expected %h", result, {16{8'h7F}});
        end
        tests++;
        if (flags !== {16{4'b0011}}) begin
            failed++;
            $display("[TB] FAIL sub_ovf_flags: got %h expected %h", flags, {16{4'b0011}});
        end
    endtask

    task automatic test_mul;
        apply_stimulus(OP_MUL, {16{8'd5}}, {16{8'd6}}, 8'd0, 1'b0);
        tests++;
        if (result !== {16{8'h1E}} || flags !== {16{4'b0000}}) begin
            failed++;
            $display("[TB] FAIL mul_small: got %h/%h expected %h/%h", result, flags,
                     {16{8'h1E}}, {16{4'b0000}});
        end
        apply_stimulus(OP_MUL, {16{8'd16}}, {16{8'd16}}, 8'd0, 1'b0);
        tests++;
        if (result !== {16{8'h00}}) begin
            failed++;
            $display("[TB] FAIL mul_ovf_result: got %h expected %h", result, {16{8'h00}});
        end
        tests++;
        if (flags !== {16{4'b0111}}) begin
            failed++;
            $display("[TB] FAIL mul_ovf_flags: got %h expected %h", flags, {16{4'b0111}});
        end
        // -3 * 5 = -15 fits in the lane.
        apply_stimulus(OP_MUL, {16{8'hFD}}, {16{8'd5}}, 8'd0, 1'b0);
        tests++;
        if (result !== {16{8'hF1}} || flags !== {16{4'b1000}}) begin
            failed++;
            $display("[TB] FAIL mul_neg: got %h/%h expected %h/%h", result, flags,
                     {16{8'hF1}}, {16{4'b1000}});
        end
        // -128 * -1 = +128 does not fit.
        apply_stimulus(OP_MUL, {16{8'h80}}, {16{8'hFF}}, 8'd0, 1'b0);
        tests++;
        if (result !== {16{8'h80}} || flags !== {16{4'b1011}}) begin
            failed++;
            $display("[TB] FAIL mul_neg_ovf: got %h/%h expected %h/%h", result, flags,
                     {16{8'h80}}, {16{4'b1011}});
        end
    endtask

    task automatic test_logic;
        apply_stimulus(OP_AND, {16{8'hF0}}, {16{8'h3C}}, 8'd0, 1'b0);
        tests++;
        if (result !== {16{8'h30}} || flags !== {16{4'b0000}}) begin
            failed++;
            $display("[TB] FAIL and_op: got %h/%h expected %h/%h", result, flags,
                     {16{8'h30}}, {16{4'b0000}});
        end
        apply_stimulus(OP_OR, {16{8'hF0}}, {16{8'h3C}}, 8'd0, 1'b0);
        tests++;
        if (result !== {16{8'hFC}} || flags !== {16{4'b1000}}) begin
            failed++;
            $display("[TB] FAIL or_op: got %h/%h expected %h/%h", result, flags,
                     {16{8'hFC}}, {16{4'b1000}});
        end
        apply_stimulus(OP_XOR, {16{8'hF0}}, {16{8'h3C}}, 8'd0, 1'b0);
        tests++;
        if (result !== {16{8'hCC}} || flags !== {16{4'b1000}}) begin
            failed++;
            $display("[TB] FAIL xor_op: got %h/%h expected %h/%h", result, flags,
                     {16{8'hCC}}, {16{4'b1000}});
        end
        apply_stimulus(OP_PASS, {16{8'hAA}}, {16{8'h00}}, 8'd0, 1'b0);
        tests++;
        if (result !== {16{8'h00}} || flags !== {16{4'b0100}}) begin
            failed++;
            $display("[TB] FAIL pass_op: got %h/%h expected %h/%h", result, flags,
                     {16{8'h00}}, {16{4'b0100}});
        end
    endtask

    task automatic test_set_scalar;
        apply_stimulus(OP_SET, {W{1'b0}}, {W{1'b0}}, 8'd42, 1'b0);
        tests++;
        if (result !== {16{8'h2A}} || flags !== {16{4'b0000}}) begin
            failed++;
            $display("[TB] FAIL set_op: got %h/%h expected %h/%h", result, flags,
                     {16{8'h2A}}, {16{4'b0000}});
        end
        // SET ignores a, b and the scalar-mode bit.
        apply_stimulus(OP_SET, {16{8'h11}}, {16{8'h22}}, 8'h80, 1'b1);
        tests++;
        if (result !== {16{8'h80}} || flags !== {16{4'b1000}}) begin
            failed++;
            $display("[TB] FAIL set_ignore: got %h/%h expected %h/%h", result, flags,
                     {16{8'h80}}, {16{4'b1000}});
        end
        apply_stimulus(OP_ADD, {16{8'd10}}, {16{8'd99}}, 8'd5, 1'b1);
        tests++;
        if (result !== {16{8'h0F}} || flags !== {16{4'b0000}}) begin
            failed++;
            $display("[TB] FAIL scalar_add: got %h/%h expected %h/%h", result, flags,
                     {16{8'h0F}}, {16{4'b0000}});
        end
        apply_stimulus(OP_PASS, {16{8'd1}}, {16{8'd2}}, 8'h9C, 1'b1);
        tests++;
        if (result !== {16{8'h9C}}) begin
            failed++;
            $display("[TB] FAIL scalar_pass: got %h expected %h", result, {16{8'h9C}});
        end
    endtask

    // Lanes 0 and 1 hit the wrap-around cases while the rest add normally,
    // showing that no carry leaks between lanes.
    task automatic test_wrap;
        apply_stimulus(OP_ADD, {{14{8'd10}}, 8'd128, 8'd250},
                       {{14{8'd20}}, 8'd128, 8'd10}, 8'd0, 1'b0);
        tests++;
        if (result !== {{14{8'h1E}}, 8'h00, 8'h04}) begin
            failed++;
            $display("[TB] FAIL wrap_result: got %h expected %h", result,
                     {{14{8'h1E}}, 8'h00, 8'h04});
        end
        tests++;
        if (flags !== {{14{4'b0000}}, 4'b0111, 4'b0010}) begin
            failed++;
            $display("[TB] FAIL wrap_flags: got %h expected %h", flags,
                     {{14{4'b0000}}, 4'b0111, 4'b0010});
        end
    endtask

    task automatic test_back_to_back;
        apply_stimulus(OP_ADD, {16{8'd1}}, {16{8'd2}}, 8'd0, 1'b0);
        tests++;
        if (result !== {16{8'h03}}) begin
            failed++;
            $display("[TB] FAIL b2b_first: got %h expected %h", result, {16{8'h03}});
        end
        // Change inputs mid-cycle: outputs must hold until the next edge.
        opcode = OP_SUB;
        a      = {16{8'd9}};
        b      = {16{8'd4}};
        #2;
        tests++;
        if (result !== {16{8'h03}}) begin
            failed++;
            $display("[TB] FAIL b2b_hold: got %h expected %h", result, {16{8'h03}});
        end
        @(posedge clk);
        #1;
        tests++;
        if (result !== {16{8'h05}} || flags !== {16{4'b0010}}) begin
            failed++;
            $display("[TB] FAIL b2b_second: got %h/%h expected %h/%h", result, flags,
                     {16{8'h05}}, {16{4'b0010}});
        end
    endtask

    task automatic test_mid_reset;
        apply_stimulus(OP_ADD, {16{8'd10}}, {16{8'd20}}, 8'd0, 1'b0);
        rst_n = 1'b0;
        apply_stimulus(OP_ADD, {16{8'd1}}, {16{8'd2}}, 8'd0, 1'b0);
        tests++;
        if (result !== '0 || flags !== '0) begin
            failed++;
            $display("[TB] FAIL midreset_clear: got %h/%h expected zero", result, flags);
        end
        rst_n = 1'b1;
        apply_stimulus(OP_ADD, {16{8'd3}}, {16{8'd4}}, 8'd0, 1'b0);
        tests++;
        if (result !== {16{8'h07}} || flags !== {16{4'b0000}}) begin
            failed++;
            $display("[TB] FAIL midreset_resume: got %h/%h expected %h/%h", result, flags,
                     {16{8'h07}}, {16{4'b0000}});
        end
    endtask

    initial begin
        tests       = 0;
        failed      = 0;
        rst_n       = 1'b0;
        a           = '0;
        b           = '0;
        c           = '0;
        opcode      = '0;
        flag_scalar = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_logic();
        test_set_scalar();
        test_wrap();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
